// File: rtl/uart_tx_feeder_if.sv
// Host-side write channel and transmitter launch handshake of the UART TX feeder.
// The master modport is the surrounding logic (host plus transmitter); the
// slave modport is the feeder itself.
interface uart_tx_feeder_if #(
    parameter int DEPTH = 16
) ();
    localparam int ADDR_W = $clog2(DEPTH);

    logic [7:0]      wr_data;
    logic            wr_valid;
    logic            wr_ready;
    logic            flush;
    logic            tx_start;
    logic [7:0]      tx_data;
    logic            tx_done;
    logic            busy;
    logic [ADDR_W:0] level;
    logic            empty;
    logic            full;

    modport master (
        output wr_data, wr_valid, flush, tx_done,
        input  wr_ready, tx_start, tx_data, busy, level, empty, full
    );

    modport slave (
        input  wr_data, wr_valid, flush, tx_done,
        output wr_ready, tx_start, tx_data, busy, level, empty, full
    );
endinterface

// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus launch controller sitting in front of the UART transmitter.
// Bytes are queued from the host on a valid/ready channel and handed to the
// transmitter one at a time: a one-cycle start pulse, data held until done.
// The byte in flight is not counted in level.
module uart_tx_feeder #(
    parameter int DEPTH = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_tx_feeder_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] LEVEL_FULL = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } state_t;

    state_t            state;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   level;
    logic [7:0]        tx_data_q;
    logic              tx_start_q;
    logic              busy_q;

    logic              full;
    logic              empty;
    logic              wr_fire;
    logic              pop;

    assign full  = (level == LEVEL_FULL);
    assign empty = (level == '0);

    // A flush drops any write presented in the same cycle.
    assign wr_fire = bus.wr_valid && !full && !bus.flush;
    // Pops only happen from IDLE, which also guarantees at most one byte in flight.
    assign pop     = (state == IDLE) && !empty && !bus.flush;

    assign bus.wr_ready = !full;
    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.busy     = busy_q;
    assign bus.level    = level;
    assign bus.empty    = empty;
    assign bus.full     = full;

    // Storage array: contents need no reset, only accepted writes land here.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (bus.flush) begin
            rd_ptr <= wr_ptr;
            level  <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({wr_fire, pop})
                2'b10:   level <= level + (ADDR_W + 1)'(1);
                2'b01:   level <= level - (ADDR_W + 1)'(1);
                default: level <= level;
            endcase
        end
    end

    // Launch controller: registered start pulse and held data for the transmitter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    tx_start_q <= 1'b0;
                    busy_q     <= 1'b0;
                    if (pop) begin
                        tx_data_q  <= mem[rd_ptr];
                        tx_start_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state      <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    // Start is high for exactly the cycle spent in LAUNCH.
                    tx_start_q <= 1'b0;
                    busy_q     <= 1'b1;
                    state      <= WAIT;
                end
                WAIT: begin
                    // No timeout: the transmitter always finishes a byte.
                    tx_start_q <= 1'b0;
                    if (bus.tx_done) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    tx_start_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder: reset, single launch, overflow and wrap,
// flush during a transfer, level-15 write+pop, and asynchronous reset.
module tb_uart_tx_feeder;
    logic clk;
    logic rst_n;

    uart_tx_feeder_if #(.DEPTH(16)) bus ();

    uart_tx_feeder #(.DEPTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_total = 0;
    int n_bad   = 0;
    logic [7:0] sent [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every launched byte, captured away from the active edge.
    always @(negedge clk) begin
        if (rst_n && bus.tx_start) sent.push_back(bus.tx_data);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for the WAIT state, then return one tx_done pulse.
    task automatic pulse_done();
        int guard = 0;
        while (!(bus.busy && !bus.tx_start) && guard < 20) begin
            tick();
            guard++;
        end
        chk("wait_bound", 32'(guard < 20), 32'd1);
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        tick();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_start"}, 32'(bus.tx_start), 32'd0);
        chk({tag, "_data"},  32'(bus.tx_data),  32'h00);
        chk({tag, "_busy"},  32'(bus.busy),     32'd0);
        chk({tag, "_level"}, 32'(bus.level),    32'd0);
        chk({tag, "_empty"}, 32'(bus.empty),    32'd1);
        chk({tag, "_full"},  32'(bus.full),     32'd0);
        chk({tag, "_ready"}, 32'(bus.wr_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        bus.wr_data  = 8'h00;
        bus.wr_valid = 1'b0;
        bus.flush    = 1'b0;
        bus.tx_done  = 1'b0;
        repeat (3) tick();
        chk_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Idle for 100 cycles: nothing launches.
        repeat (100) tick();
        chk_reset_outputs("idle");
        chk("idle_nstart", 32'(sent.size()), 32'd0);

        // Single byte: launch one cycle after the write edge, one-cycle pulse.
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'hA5;
        tick();
        bus.wr_valid = 1'b0;
        chk("a5_lvl1",   32'(bus.level),    32'd1);
        chk("a5_nostart",32'(bus.tx_start), 32'd0);
        tick();
        chk("a5_start",  32'(bus.tx_start), 32'd1);
        chk("a5_data",   32'(bus.tx_data),  32'hA5);
        chk("a5_busy",   32'(bus.busy),     32'd1);
        chk("a5_lvl0",   32'(bus.level),    32'd0);
        tick();
        chk("a5_pulse1", 32'(bus.tx_start), 32'd0);
        chk("a5_busy2",  32'(bus.busy),     32'd1);
        repeat (200) tick();
        chk("a5_hold",   32'(bus.tx_data),  32'hA5);
        chk("a5_wait",   32'(bus.busy),     32'd1);
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        chk("a5_idle",   32'(bus.busy),     32'd0);
        chk("a5_nstart", 32'(sent.size()),  32'd1);

        // Overflow: 20 bytes with tx_done withheld; 00 in flight, 01..10 queued.
        sent.delete();
        for (int i = 0; i < 20; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = 8'(i);
            tick();
        end
        bus.wr_valid = 1'b0;
        chk("ovf_level", 32'(bus.level),    32'd16);
        chk("ovf_full",  32'(bus.full),     32'd1);
        chk("ovf_ready", 32'(bus.wr_ready), 32'd0);
        chk("ovf_data",  32'(bus.tx_data),  32'h00);
        chk("ovf_n1",    32'(sent.size()),  32'd1);
        for (int i = 0; i < 17; i++) pulse_done();
        chk("ovf_nsent", 32'(sent.size()),  32'd17);
        for (int k = 0; k < 17; k++) chk($sformatf("ovf_seq%0d", k), 32'(sent[k]), 32'(k));
        chk("ovf_empty", 32'(bus.empty),    32'd1);
        chk("ovf_idle",  32'(bus.busy),     32'd0);

        // Flush while byte 0 is in WAIT; a write in the flush cycle is dropped.
        sent.delete();
        for (int i = 0; i < 3; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = 8'hB0 + 8'(i);
            tick();
        end
        bus.wr_valid = 1'b0;
        tick();
        chk("fl_pre",    32'(bus.level),    32'd2);
        bus.flush    = 1'b1;
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'hEE;
        tick();
        bus.flush    = 1'b0;
        bus.wr_valid = 1'b0;
        chk("fl_level",  32'(bus.level),    32'd0);
        chk("fl_empty",  32'(bus.empty),    32'd1);
        chk("fl_busy",   32'(bus.busy),     32'd1);
        chk("fl_data",   32'(bus.tx_data),  32'hB0);
        pulse_done();
        chk("fl_done",   32'(bus.busy),     32'd0);
        repeat (20) tick();
        chk("fl_nsent",  32'(sent.size()),  32'd1);
        chk("fl_byte0",  32'(sent[0]),      32'hB0);

        // Level 15 with simultaneous write and pop from IDLE.
        sent.delete();
        for (int i = 0; i < 16; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = 8'h40 + 8'(i);
            tick();
        end
        bus.wr_valid = 1'b0;
        chk("l15_level", 32'(bus.level),    32'd15);
        chk("l15_full0", 32'(bus.full),     32'd0);
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done  = 1'b0;
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'h50;
        tick();
        bus.wr_valid = 1'b0;
        chk("l15_keep",  32'(bus.level),    32'd15);
        chk("l15_full",  32'(bus.full),     32'd0);
        chk("l15_start", 32'(bus.tx_start), 32'd1);
        chk("l15_data",  32'(bus.tx_data),  32'h41);
        for (int i = 0; i < 16; i++) pulse_done();
        chk("l15_nsent", 32'(sent.size()),  32'd17);
        for (int k = 0; k < 17; k++) chk($sformatf("l15_seq%0d", k), 32'(sent[k]), 32'h40 + 32'(k));

        // Asynchronous reset in WAIT with five bytes queued.
        for (int i = 0; i < 6; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = 8'h60 + 8'(i);
            tick();
        end
        bus.wr_valid = 1'b0;
        tick();
        chk("ar_level",  32'(bus.level),    32'd5);
        chk("ar_busy",   32'(bus.busy),     32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("ar");
        sent.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) tick();
        chk("ar_nstart", 32'(sent.size()),  32'd0);
        chk("ar_empty",  32'(bus.empty),    32'd1);
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'h77;
        tick();
        bus.wr_valid = 1'b0;
        tick();
        chk("ar_start",  32'(bus.tx_start), 32'd1);
        chk("ar_data",   32'(bus.tx_data),  32'h77);
        pulse_done();
        chk("ar_done",   32'(bus.busy),     32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
